// File: rtl/sd_card_cmd_responder.sv
// Card-side SD CMD line endpoint: receives 48-bit host commands, checks framing/CRC7,
// and serialises a 48-bit short response after the NCR gap.
module sd_card_cmd_responder #(
  parameter int gNcr         = 2,
  parameter int gRespTimeout = 64
) (
  input  logic        Clk,
  input  logic        nResetAsync,
  input  logic        iCmd,
  output logic        oCmd,
  output logic        oCmdEn,
  output logic        oCmdValid,
  output logic [5:0]  oIndex,
  output logic [31:0] oArg,
  output logic        oCrcError,
  output logic        oFrameError,
  output logic        oTimeout,
  input  logic        iRespValid,
  input  logic [5:0]  iRespIndex,
  input  logic [31:0] iRespArg,
  input  logic        iRespNoCrc,
  input  logic        iNoResp,
  output logic        oBusy
);

  localparam int TW = $clog2(gRespTimeout + 1);
  localparam logic [6:0]    GapLast = 7'(gNcr - 1);
  localparam logic [TW-1:0] ToLast  = TW'(gRespTimeout - 1);

  typedef enum logic [2:0] {Idle, Recv, Check, WaitResp, Send} state_t;

  state_t        state;
  logic [46:0]   rsr;
  logic [5:0]    cnt;
  logic [6:0]    crc;
  logic [6:0]    gap;
  logic [TW-1:0] wcnt;
  logic          have;
  logic [5:0]    ridx;
  logic [31:0]   rarg;
  logic          rnocrc;
  logic [38:0]   tsr;
  logic [6:0]    tcrc;
  logic [6:0]    tcrc_nxt;

  function automatic logic [6:0] crc7(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:3], c[2] ^ fb, c[1:0], fb};
  endfunction

  // Transmit CRC folds in the bit currently on the line.
  assign tcrc_nxt = crc7(tcrc, oCmd);
  assign oBusy    = (state != Idle);

  always_ff @(posedge Clk or negedge nResetAsync) begin
    if (!nResetAsync) begin
      state       <= Idle;
      oCmd        <= 1'b1;
      oCmdEn      <= 1'b0;
      oCmdValid   <= 1'b0;
      oCrcError   <= 1'b0;
      oFrameError <= 1'b0;
      oTimeout    <= 1'b0;
      oIndex      <= '0;
      oArg        <= '0;
      rsr         <= '0;
      cnt         <= '0;
      crc         <= '0;
      gap         <= '0;
      wcnt        <= '0;
      have        <= 1'b0;
      ridx        <= '0;
      rarg        <= '0;
      rnocrc      <= 1'b0;
      tsr         <= '0;
      tcrc        <= '0;
    end else begin
      oCmdValid   <= 1'b0;
      oCrcError   <= 1'b0;
      oFrameError <= 1'b0;
      oTimeout    <= 1'b0;
      case (state)
        Idle: begin
          if (!iCmd) begin
            state <= Recv;
            cnt   <= '0;
            crc   <= '0;
          end
        end
        Recv: begin
          rsr <= {rsr[45:0], iCmd};
          cnt <= cnt + 6'd1;
          if (cnt <= 6'd38) crc <= crc7(crc, iCmd);
          if (cnt == 6'd46) begin
            state <= Check;
            gap   <= '0;
          end
        end
        Check: begin
          wcnt <= '0;
          have <= 1'b0;
          if (!rsr[46]) begin
            oFrameError <= 1'b1;
            state       <= Idle;
          end else if (rsr[7:1] != crc || !rsr[0]) begin
            oCrcError <= 1'b1;
            state     <= Idle;
          end else begin
            oCmdValid <= 1'b1;
            oIndex    <= rsr[45:40];
            oArg      <= rsr[39:8];
            gap       <= gap + 7'd1;
            state     <= WaitResp;
            // A response already presented here still honours the full gap.
            if (iRespValid && !iNoResp) begin
              have   <= 1'b1;
              ridx   <= iRespIndex;
              rarg   <= iRespArg;
              rnocrc <= iRespNoCrc;
            end
          end
        end
        WaitResp: begin
          if (gap != GapLast) gap <= gap + 7'd1;
          if (iNoResp) begin
            state <= Idle;
          end else if (have && gap == GapLast) begin
            state  <= Send;
            oCmdEn <= 1'b1;
            oCmd   <= 1'b0;
            cnt    <= '0;
            tsr    <= {1'b0, ridx, rarg};
            tcrc   <= '0;
          end else if (!have) begin
            if (iRespValid) begin
              have   <= 1'b1;
              ridx   <= iRespIndex;
              rarg   <= iRespArg;
              rnocrc <= iRespNoCrc;
            end else if (wcnt == ToLast) begin
              oTimeout <= 1'b1;
              state    <= Idle;
            end else begin
              wcnt <= wcnt + TW'(1);
            end
          end
        end
        Send: begin
          cnt <= cnt + 6'd1;
          if (cnt <= 6'd38) begin
            oCmd <= tsr[38];
            tsr  <= {tsr[37:0], 1'b0};
            tcrc <= tcrc_nxt;
          end else if (cnt == 6'd39) begin
            oCmd <= rnocrc | tcrc_nxt[6];
            tcrc <= {tcrc_nxt[5:0], 1'b1};
          end else if (cnt <= 6'd45) begin
            oCmd <= rnocrc | tcrc[6];
            tcrc <= {tcrc[5:0], 1'b1};
          end else if (cnt == 6'd46) begin
            oCmd <= 1'b1;
          end else begin
            oCmd   <= 1'b1;
            oCmdEn <= 1'b0;
            state  <= Idle;
          end
        end
        default: state <= Idle;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_card_cmd_responder.sv
// Directed bench: two responders (gNcr=2 and gNcr=8) share stimulus, steered by sel.
module tb_sd_card_cmd_responder;

  logic        Clk;
  logic        nResetAsync;
  logic        cmd, sel;
  logic        rv, rnc, nr;
  logic [5:0]  ri;
  logic [31:0] ra;
  logic        cmd_a, cmd_b;

  logic        a_cmd, a_en, a_vld, a_cerr, a_ferr, a_tout, a_busy;
  logic [5:0]  a_idx;
  logic [31:0] a_arg;
  logic        b_cmd, b_en, b_vld, b_cerr, b_ferr, b_tout, b_busy;
  logic [5:0]  b_idx;
  logic [31:0] b_arg;

  logic        ocmd, en, vld, cerr, ferr, tout, busy;
  logic [5:0]  idx;
  logic [31:0] arg;

  int n_chk = 0;
  int n_fail = 0;

  localparam logic [47:0] CMD0  = 48'h40_00000000_95;
  localparam logic [47:0] CMD8  = 48'h48_000001AA_87;
  localparam logic [47:0] CMD55 = 48'h77_00000000_65;
  localparam logic [47:0] R7    = 48'h08_000001AA_13;
  localparam logic [47:0] R3    = 48'h3F_80FF8000_FF;

  assign cmd_a = sel ? 1'b1 : cmd;
  assign cmd_b = sel ? cmd : 1'b1;
  assign ocmd  = sel ? b_cmd  : a_cmd;
  assign en    = sel ? b_en   : a_en;
  assign vld   = sel ? b_vld  : a_vld;
  assign cerr  = sel ? b_cerr : a_cerr;
  assign ferr  = sel ? b_ferr : a_ferr;
  assign tout  = sel ? b_tout : a_tout;
  assign busy  = sel ? b_busy : a_busy;
  assign idx   = sel ? b_idx  : a_idx;
  assign arg   = sel ? b_arg  : a_arg;

  sd_card_cmd_responder #(.gNcr(2), .gRespTimeout(64)) u_a (
    .Clk(Clk), .nResetAsync(nResetAsync), .iCmd(cmd_a), .oCmd(a_cmd), .oCmdEn(a_en),
    .oCmdValid(a_vld), .oIndex(a_idx), .oArg(a_arg), .oCrcError(a_cerr),
    .oFrameError(a_ferr), .oTimeout(a_tout), .iRespValid(rv), .iRespIndex(ri),
    .iRespArg(ra), .iRespNoCrc(rnc), .iNoResp(nr), .oBusy(a_busy));

  sd_card_cmd_responder #(.gNcr(8), .gRespTimeout(64)) u_b (
    .Clk(Clk), .nResetAsync(nResetAsync), .iCmd(cmd_b), .oCmd(b_cmd), .oCmdEn(b_en),
    .oCmdValid(b_vld), .oIndex(b_idx), .oArg(b_arg), .oCrcError(b_cerr),
    .oFrameError(b_ferr), .oTimeout(b_tout), .iRespValid(rv), .iRespIndex(ri),
    .iRespArg(ra), .iRespNoCrc(rnc), .iNoResp(nr), .oBusy(b_busy));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Leaves the caller 1 ns after the edge that sampled the end bit.
  task automatic send_cmd(input logic [47:0] f);
    for (int i = 47; i >= 0; i--) begin
      cmd = f[i];
      @(posedge Clk); #1;
    end
    cmd = 1'b1;
  endtask

  task automatic capture(output logic [47:0] v, output int n);
    v = '0;
    n = 0;
    for (int k = 0; k < 60; k++) begin
      if (!en) break;
      v = {v[46:0], ocmd};
      n++;
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_reset();
    n_chk++; if (en !== 1'b0 || b_en !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %b/%b want 0", en, b_en); end
    n_chk++; if (ocmd !== 1'b1) begin n_fail++; $display("FAIL reset_cmd: got %b want 1", ocmd); end
    n_chk++; if (busy !== 1'b0 || vld !== 1'b0 || cerr !== 1'b0 || ferr !== 1'b0 || tout !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: busy %b vld %b cerr %b ferr %b tout %b want 0", busy, vld, cerr, ferr, tout); end
    n_chk++; if (idx !== 6'd0 || arg !== 32'd0) begin n_fail++; $display("FAIL reset_idxarg: got %h/%h want 0/0", idx, arg); end
  endtask

  task automatic test_cmd0();
    logic drove;
    sel = 0; rv = 0; nr = 0;
    send_cmd(CMD0);
    drove = en;
    @(posedge Clk); #1;
    n_chk++; if (vld !== 1'b1) begin n_fail++; $display("FAIL cmd0_valid: got %b want 1", vld); end
    n_chk++; if (idx !== 6'd0 || arg !== 32'd0) begin n_fail++; $display("FAIL cmd0_idxarg: got %h/%h want 0/0", idx, arg); end
    nr = 1;
    @(posedge Clk); #1;
    nr = 0;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cmd0_busy: got %b want 0", busy); end
    repeat (60) begin
      if (en) drove = 1'b1;
      @(posedge Clk); #1;
    end
    n_chk++; if (drove !== 1'b0) begin n_fail++; $display("FAIL cmd0_nodrive: got %b want 0", drove); end
  endtask

  task automatic test_cmd8();
    logic [47:0] v;
    int n;
    sel = 0; rv = 1; ri = 6'd8; ra = 32'h000001AA; rnc = 0;
    send_cmd(CMD8);
    n_chk++; if (en !== 1'b0) begin n_fail++; $display("FAIL cmd8_en_e0: got %b want 0", en); end
    @(posedge Clk); #1;
    n_chk++; if (vld !== 1'b1 || en !== 1'b0) begin n_fail++; $display("FAIL cmd8_valid: vld %b en %b want 1/0", vld, en); end
    n_chk++; if (idx !== 6'd8 || arg !== 32'h000001AA) begin n_fail++; $display("FAIL cmd8_idxarg: got %h/%h want 08/000001aa", idx, arg); end
    @(posedge Clk); #1;
    rv = 0;
    n_chk++; if (en !== 1'b1) begin n_fail++; $display("FAIL cmd8_en_rise: got %b want 1", en); end
    capture(v, n);
    n_chk++; if (n != 48) begin n_fail++; $display("FAIL cmd8_len: got %0d want 48", n); end
    n_chk++; if (v !== R7) begin n_fail++; $display("FAIL cmd8_resp: got %h want %h", v, R7); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cmd8_idle: got %b want 0", busy); end
  endtask

  task automatic test_errors();
    logic [47:0] v;
    int n;
    sel = 0; rv = 1; ri = 6'd8; ra = 32'h000001AA; rnc = 0;
    send_cmd(48'h48_000001AB_87);
    @(posedge Clk); #1;
    n_chk++; if (cerr !== 1'b1 || vld !== 1'b0 || ferr !== 1'b0) begin
      n_fail++; $display("FAIL crc_flip: cerr %b vld %b ferr %b want 1/0/0", cerr, vld, ferr); end
    n_chk++; if (en !== 1'b0) begin n_fail++; $display("FAIL crc_flip_nodrive: got %b want 0", en); end
    send_cmd(CMD8);
    @(posedge Clk); #1;
    n_chk++; if (vld !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %b want 1", vld); end
    @(posedge Clk); #1;
    rv = 0;
    n_chk++; if (en !== 1'b1) begin n_fail++; $display("FAIL b2b_en: got %b want 1", en); end
    capture(v, n);
    n_chk++; if (v !== R7 || n != 48) begin n_fail++; $display("FAIL b2b_resp: got %h/%0d want %h/48", v, n, R7); end
    send_cmd(48'h08_000001AA_87);
    @(posedge Clk); #1;
    n_chk++; if (ferr !== 1'b1 || cerr !== 1'b0 || vld !== 1'b0) begin
      n_fail++; $display("FAIL frame_err: ferr %b cerr %b vld %b want 1/0/0", ferr, cerr, vld); end
    send_cmd(48'h48_000001AA_86);
    @(posedge Clk); #1;
    n_chk++; if (cerr !== 1'b1 || vld !== 1'b0) begin n_fail++; $display("FAIL endbit_err: cerr %b vld %b want 1/0", cerr, vld); end
    @(posedge Clk); #1;
    n_chk++; if (busy !== 1'b0 || en !== 1'b0) begin n_fail++; $display("FAIL err_idle: busy %b en %b want 0/0", busy, en); end
  endtask

  task automatic test_r3();
    logic [47:0] v;
    int n;
    sel = 0; rv = 1; ri = 6'h3F; ra = 32'h80FF8000; rnc = 1;
    send_cmd(CMD55);
    @(posedge Clk); #1;
    n_chk++; if (vld !== 1'b1 || idx !== 6'h37) begin n_fail++; $display("FAIL r3_valid: vld %b idx %h want 1/37", vld, idx); end
    @(posedge Clk); #1;
    rv = 0;
    capture(v, n);
    rnc = 0;
    n_chk++; if (v !== R3 || n != 48) begin n_fail++; $display("FAIL r3_resp: got %h/%0d want %h/48", v, n, R3); end
  endtask

  task automatic test_timeout();
    int k;
    logic drove;
    sel = 1; rv = 0; nr = 0; drove = 0;
    send_cmd(CMD55);
    @(posedge Clk); #1;
    n_chk++; if (vld !== 1'b1) begin n_fail++; $display("FAIL to_valid: got %b want 1", vld); end
    k = 0;
    while (!tout && k < 100) begin
      @(posedge Clk); #1;
      k++;
      if (en) drove = 1'b1;
    end
    n_chk++; if (k != 64) begin n_fail++; $display("FAIL to_cycles: got %0d want 64", k); end
    n_chk++; if (busy !== 1'b0 || drove !== 1'b0) begin n_fail++; $display("FAIL to_idle: busy %b drove %b want 0/0", busy, drove); end
  endtask

  task automatic test_late();
    logic [47:0] v;
    int n;
    logic drove;
    sel = 1; rv = 0; nr = 0; ri = 6'd8; ra = 32'h000001AA; rnc = 0; drove = 0;
    send_cmd(CMD55);
    repeat (19) begin
      @(posedge Clk); #1;
      if (en) drove = 1'b1;
    end
    rv = 1;
    @(posedge Clk); #1;
    rv = 0;
    if (en) drove = 1'b1;
    n_chk++; if (drove !== 1'b0) begin n_fail++; $display("FAIL late_early: got %b want 0", drove); end
    @(posedge Clk); #1;
    n_chk++; if (en !== 1'b1 || ocmd !== 1'b0) begin n_fail++; $display("FAIL late_start: en %b cmd %b want 1/0", en, ocmd); end
    capture(v, n);
    n_chk++; if (v !== R7 || n != 48) begin n_fail++; $display("FAIL late_resp: got %h/%0d want %h/48", v, n, R7); end
  endtask

  task automatic test_reset_mid_send();
    sel = 0; rv = 1; ri = 6'd8; ra = 32'h000001AA; rnc = 0;
    send_cmd(CMD8);
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    rv = 0;
    repeat (20) @(posedge Clk);
    #3;
    n_chk++; if (en !== 1'b1) begin n_fail++; $display("FAIL rst_pre: got %b want 1", en); end
    nResetAsync = 0;
    #1;
    n_chk++; if (en !== 1'b0 || ocmd !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_async: en %b cmd %b busy %b want 0/1/0", en, ocmd, busy); end
    @(posedge Clk); #2;
    nResetAsync = 1;
    @(posedge Clk); #1;
    send_cmd(CMD55);
    @(posedge Clk); #1;
    n_chk++; if (vld !== 1'b1 || idx !== 6'h37 || arg !== 32'd0) begin
      n_fail++; $display("FAIL rst_cmd55: vld %b idx %h arg %h want 1/37/0", vld, idx, arg); end
    nr = 1;
    @(posedge Clk); #1;
    nr = 0;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_cmd55_idle: got %b want 0", busy); end
  endtask

  initial begin
    nResetAsync = 0; cmd = 1; sel = 0;
    rv = 0; rnc = 0; nr = 0; ri = '0; ra = '0;
    #12;
    test_reset();
    nResetAsync = 1;
    @(posedge Clk); #1;
    test_cmd0();
    test_cmd8();
    test_errors();
    test_r3();
    test_timeout();
    test_late();
    test_reset_mid_send();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
